dig_scan: RTL and testbench

//  Time-multiplexed scanner for a DIGITS-digit 7-segment display. Holds a packed
//  hex value, sequences one digit at a time and drives that digit's nibble onto
//  x0..x3 (x0 = MSB) of the combinational nibble-to-segment decoder downstream,

---
 rtl/dig_scan.sv | 134 +++++++++++++
 tb/tb_dig_scan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dig_scan.sv
// Time-multiplexed 7-segment digit scanner with a double-buffered display value.
// Define DIG_LZB_EN to blank leading-zero digits (digit 0 is always lit).
module dig_scan #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   din,
  output logic [DIGITS-1:0]     an,
  output logic                  x0,
  output logic                  x1,
  output logic                  x2,
  output logic                  x3,
  output logic                  pend
);

  localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(DIV);

  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;

  localparam logic [SW-1:0] SEL_LAST = SW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic                state_q,  state_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic [SW-1:0]       sel_q,    sel_d;
  logic [4*DIGITS-1:0] disp_q,   disp_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pend_q,   pend_d;
  logic [DIGITS-1:0]   an_q,     an_d;
  logic [3:0]          x_q,      x_d;

  logic tick;
  logic wrap;
  logic [3:0] nib;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (sel_q == SEL_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = '0;
        if (ld) begin
          disp_d  = din;
          state_d = SCAN;
        end
      end
      default: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) sel_d = wrap ? '0 : sel_q + 1'b1;
        // Commit at the frame boundary first; a coincident load then refills the shadow.
        if (wrap && pend_q) begin
          disp_d = shadow_q;
          pend_d = 1'b0;
        end
        if (ld) begin
          shadow_d = din;
          pend_d   = 1'b1;
        end
      end
    endcase
  end

`ifdef DIG_LZB_EN
  logic upper_zero;
`endif

  always_comb begin
    nib = '0;
`ifdef DIG_LZB_EN
    upper_zero = 1'b1;
`endif
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (SW'(i) == sel_q) nib = disp_q[4*i +: 4];
`ifdef DIG_LZB_EN
      if (SW'(i) >= sel_q && disp_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
`endif
    end
    an_d = '1;
    x_d  = '0;
    if (state_q == SCAN) begin
      an_d = ~(DIGITS'(1) << sel_q);
      x_d  = nib;
`ifdef DIG_LZB_EN
      if (sel_q != '0 && upper_zero) begin
        an_d = '1;
        x_d  = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= '1;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      x_q      <= x_d;
    end
  end

  assign an   = an_q;
  assign x0   = x_q[3];
  assign x1   = x_q[2];
  assign x2   = x_q[1];
  assign x3   = x_q[0];
  assign pend = pend_q;

endmodule

// File: tb/tb_dig_scan.sv
// Randomized self-checking bench for dig_scan against a time-based display model.
module tb_dig_scan;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned FRAME  = DIGITS * DIV;

  logic        clk;
  logic        reset;
  logic        ld;
  logic [15:0] din;
  logic [3:0]  an;
  logic        x0, x1, x2, x3;
  logic        pend;

  int checks = 0;
  int errors = 0;

  // Reference model: display position derived from elapsed scan time.
  bit          m_scan;
  int unsigned m_t;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  bit          m_pend;
  logic [3:0]  m_an;
  logic [3:0]  m_x;

  dig_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .din   (din),
    .an    (an),
    .x0    (x0),
    .x1    (x1),
    .x2    (x2),
    .x3    (x3),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
    m_an = 4'hF; m_x = 4'h0;
  endtask

  task automatic model_edge(input logic l, input logic [15:0] d);
    int unsigned dig;
    logic [15:0] upper;
    if (m_scan) begin
      dig   = (m_t / DIV) % DIGITS;
      upper = m_disp >> (4 * dig);
      m_an  = ~(4'd1 << dig);
      m_x   = upper[3:0];
`ifdef DIG_LZB_EN
      if (dig > 0 && upper == 16'h0) begin
        m_an = 4'hF;
        m_x  = 4'h0;
      end
`endif
    end else begin
      m_an = 4'hF;
      m_x  = 4'h0;
    end
    if (!m_scan) begin
      if (l) begin
        m_disp = d;
        m_scan = 1;
        m_t    = 0;
      end
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end
      if (l) begin
        m_shadow = d;
        m_pend   = 1;
      end
      m_t++;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".an"},   {28'h0, an}, {28'h0, m_an});
    check({tag, ".x"},    {28'h0, x0, x1, x2, x3}, {28'h0, m_x});
    check({tag, ".pend"}, {31'h0, pend}, {31'h0, m_pend});
  endtask

  task automatic step(input string tag, input logic l, input logic [15:0] d);
    ld  = l;
    din = d;
    @(posedge clk);
    model_edge(l, d);
    #1;
    check_outs(tag);
    ld = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".an"},   {28'h0, an}, 32'hF);
    check({tag, ".x"},    {28'h0, x0, x1, x2, x3}, 32'h0);
    check({tag, ".pend"}, {31'h0, pend}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic to_wrap_cycle(input string tag);
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) step(tag, 1'b0, 16'h0);
  endtask

  initial begin
    reset = 1'b0;
    ld    = 1'b0;
    din   = '0;
    model_reset();
    #2 reset = 1'b1;
    #1;
    check("rst.an",   {28'h0, an}, 32'hF);
    check("rst.x",    {28'h0, x0, x1, x2, x3}, 32'h0);
    check("rst.pend", {31'h0, pend}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    run("idle", 5);

    step("load1234", 1'b1, 16'h1234);
    step("first", 1'b0, 16'h0);
    check("first.an_const", {28'h0, an}, 32'hE);
    check("first.x_const",  {28'h0, x0, x1, x2, x3}, 32'h4);
    run("frame1234", 2 * FRAME);

    run("mid", 5);
    step("ldABCD", 1'b1, 16'hABCD);
    check("ldABCD.pend_const", {31'h0, pend}, 32'h1);
    run("abcd", 2 * FRAME);

    run("b2b_pre", 3);
    step("ld5555", 1'b1, 16'h5555);
    step("ld6666", 1'b1, 16'h6666);
    run("b2b", 2 * FRAME);

    run("wrap_pre", 2);
    step("ld7777", 1'b1, 16'h7777);
    to_wrap_cycle("wrap_wait");
    to_wrap_cycle("wrap_wait2");
    step("ld8888", 1'b1, 16'h8888);
    check("wrap.pend_const", {31'h0, pend}, 32'h1);
    run("wrap", 3 * FRAME);

    step("ld0012", 1'b1, 16'h0012);
    run("lzb12", 2 * FRAME + 2);
    step("ld0000", 1'b1, 16'h0000);
    run("lzb00", 2 * FRAME + 2);

    run("midreset_pre", 6);
    step("midreset_ld", 1'b1, 16'h4321);
    async_reset("midreset");
    run("after_reset_idle", 4);

    step("rnd_start", 1'b1, 16'($urandom));
    for (int i = 0; i < 800; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      step("rnd", ($urandom_range(0, 7) == 0), d);
      if (i == 400) begin
        async_reset("rnd_reset");
        step("rnd_reload", 1'b1, 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
